// File: rtl/jt1943_snd_pkg.sv
// Shared sound definitions: output gain encodings and default decimator sizing.
package jt1943_snd_pkg;

    typedef enum logic [1:0] {
        GAIN_MUTE   = 2'd0,
        GAIN_HALF   = 2'd1,
        GAIN_UNITY  = 2'd2,
        GAIN_DOUBLE = 2'd3
    } gain_e;

    localparam int SND_DW    = 16;
    localparam int SND_DLOG2 = 5;
    localparam int SND_FLOG2 = 2;

endpackage

// File: rtl/jt1943_snd_fifo.sv
// Small show-ahead FIFO holding decimated samples; head entry is always visible on dout.
module jt1943_snd_fifo
    import jt1943_snd_pkg::*;
#(
    parameter int DW    = SND_DW,
    parameter int FLOG2 = SND_FLOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << FLOG2;

    logic [DW-1:0]    mem [DEPTH];
    logic [FLOG2-1:0] wr_ptr_reg;
    logic [FLOG2-1:0] rd_ptr_reg;
    logic [FLOG2:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == (FLOG2+1)'(DEPTH));
    assign empty = (count_reg == '0);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_reg] <= din;
                wr_ptr_reg      <= wr_ptr_reg + FLOG2'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + FLOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (FLOG2+1)'(1);
                2'b01:   count_reg <= count_reg - (FLOG2+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/jt1943_snd_decim.sv
// Sound decimator: box-filters 2^DLOG2 input samples into one, applies gain, queues results.
module jt1943_snd_decim
    import jt1943_snd_pkg::*;
#(
    parameter int DW    = SND_DW,
    parameter int DLOG2 = SND_DLOG2,
    parameter int FLOG2 = SND_FLOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen1p5,
    input  logic signed [DW-1:0] snd,
    input  logic [1:0]           gain,
    output logic signed [DW-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 ovf
);

    localparam int AW = DW + DLOG2;

    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] sum;
    logic [DLOG2-1:0]     cnt_reg;
    logic [DW-1:0]        st1_reg;
    logic                 st1_valid_reg;
    logic [DW-1:0]        st2_reg;
    logic                 st2_valid_reg;
    logic [DW-1:0]        gained;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic [DW-1:0]        fifo_dout;

    assign sum = acc_reg + {{DLOG2{snd[DW-1]}}, snd};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            st1_reg       <= '0;
            st1_valid_reg <= 1'b0;
        end else begin
            st1_valid_reg <= 1'b0;
            if (cen1p5) begin
                cnt_reg <= cnt_reg + DLOG2'(1);
                if (cnt_reg == '1) begin
                    // Dropping the low DLOG2 bits is the floor of the block mean.
                    st1_reg       <= sum[AW-1:DLOG2];
                    acc_reg       <= '0;
                    st1_valid_reg <= 1'b1;
                end else begin
                    acc_reg <= sum;
                end
            end
        end
    end

    always_comb begin
        gained = st1_reg;
        case (gain_e'(gain))
            GAIN_MUTE:   gained = '0;
            GAIN_HALF:   gained = {st1_reg[DW-1], st1_reg[DW-1:1]};
            GAIN_UNITY:  gained = st1_reg;
            GAIN_DOUBLE: begin
                // Top two bits differing means the doubled value leaves the signed range.
                if (st1_reg[DW-1] != st1_reg[DW-2])
                    gained = st1_reg[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
                else
                    gained = {st1_reg[DW-2:0], 1'b0};
            end
            default:     gained = st1_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st2_reg       <= '0;
            st2_valid_reg <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            st2_valid_reg <= st1_valid_reg;
            if (st1_valid_reg) begin
                st2_reg <= gained;
            end
            if (st2_valid_reg && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign pop          = sample_valid && sample_ready;
    assign sample_valid = !fifo_empty;
    assign sample       = fifo_dout;

    jt1943_snd_fifo #(
        .DW    (DW),
        .FLOG2 (FLOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (st2_valid_reg),
        .din   (st2_reg),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_jt1943_snd_decim.sv
// Directed bench for the sound decimator: block averages, gain, latency, FIFO overflow, reset.
module tb_jt1943_snd_decim;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cen1p5 = 1'b0;
    logic signed [15:0] snd = '0;
    logic [1:0]         gain = 2'd2;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               sample_ready = 1'b0;
    logic               ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jt1943_snd_decim #(.DW(16), .DLOG2(5), .FLOG2(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen1p5       (cen1p5),
        .snd          (snd),
        .gain         (gain),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .ovf          (ovf)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic strobes(input int n, input int v0, input int dv);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cen1p5 = 1'b1;
            snd = 16'(v0 + i * dv);
        end
        @(negedge clk);
        cen1p5 = 1'b0;
    endtask

    // Waits (bounded) for a head sample, checks it, then pops it.
    task automatic take(input string tag, input int exp);
        int n = 0;
        while (!sample_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'b0, sample_valid}, 1);
        chk(tag, $signed(sample), exp);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        $display("txn %s: sample=%0d", tag, sample);
    endtask

    initial begin
        pulse_rst();
        chk("rst_valid", {31'b0, sample_valid}, 0);
        chk("rst_sample", $signed(sample), 0);
        chk("rst_ovf", {31'b0, ovf}, 0);

        // Constant 1000 at unity gain, latency of two edges after the last strobe
        gain = 2'd2;
        sample_ready = 1'b1;
        strobes(32, 1000, 0);
        chk("lat_e0", {31'b0, sample_valid}, 0);
        @(negedge clk);
        chk("lat_e1", {31'b0, sample_valid}, 0);
        @(negedge clk);
        chk("lat_e2", {31'b0, sample_valid}, 1);
        chk("const1000", $signed(sample), 1000);
        $display("txn const1000: sample=%0d", sample);
        @(negedge clk);
        chk("const_popped", {31'b0, sample_valid}, 0);
        sample_ready = 1'b0;

        // Gain: saturation both ways, floor halving, mute
        gain = 2'd3;
        strobes(32, 20000, 0);
        take("dbl_pos", 32767);
        strobes(32, -20000, 0);
        take("dbl_neg", -32768);
        gain = 2'd1;
        strobes(32, -3, 0);
        take("half_neg3", -2);
        gain = 2'd0;
        strobes(32, 1000, 0);
        take("mute", 0);

        // Ramp 0..31 averages to floor(496/32)
        gain = 2'd2;
        strobes(32, 0, 1);
        take("ramp", 15);

        // Overflow: five blocks with no consumer
        for (int b = 1; b <= 5; b++) strobes(32, b * 100, 0);
        repeat (3) @(negedge clk);
        chk("ovf_set", {31'b0, ovf}, 1);
        for (int b = 1; b <= 4; b++) take($sformatf("drain%0d", b), b * 100);
        repeat (2) @(negedge clk);
        chk("drain_empty", {31'b0, sample_valid}, 0);

        // Reset mid-block discards the partial sum and clears ovf
        strobes(10, 500, 0);
        pulse_rst();
        chk("rst2_ovf", {31'b0, ovf}, 0);
        strobes(32, 100, 0);
        take("after_rst", 100);
        chk("after_rst_ovf", {31'b0, ovf}, 0);

        // Full FIFO with a pop on the push edge: nothing dropped
        for (int b = 1; b <= 4; b++) strobes(32, b * 11, 0);
        repeat (3) @(negedge clk);
        strobes(32, 55, 0);
        @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        @(negedge clk);
        chk("full_pop_ovf", {31'b0, ovf}, 0);
        for (int b = 2; b <= 5; b++) take($sformatf("full_drain%0d", b), b * 11);
        repeat (2) @(negedge clk);
        chk("full_drain_empty", {31'b0, sample_valid}, 0);
        chk("full_end_ovf", {31'b0, ovf}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jt1943_snd_decim.md
JT1943_SND_DECIM -- requirements
Module: jt1943_snd_decim

Interface
REQ-001 Parameter DW, 16, width of the signed mixed-sound input and output sample.
REQ-002 Parameter DLOG2, 5, log2 of the decimation ratio (32 input samples per output sample).
REQ-003 Parameter FLOG2, 2, log2 of the output FIFO depth (4 entries).
REQ-004 Port clk  input  1  system clock (24 MHz).
REQ-005 Port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 Port cen1p5  input  1  input-sample strobe; snd is sampled only when high.
REQ-007 Port snd  input  DW  signed mixed sound from the sound stage.
REQ-008 Port gain  input  2  output gain: 0 mute, 1 -6 dB, 2 unity, 3 +6 dB.
REQ-009 Port sample  output  DW  signed decimated sample at the FIFO head.
REQ-010 Port sample_valid  output  1  FIFO not empty; sample is meaningful.
REQ-011 Port sample_ready  input  1  consumer accepts sample on clk edge when sample_valid is also high.
REQ-012 Port ovf  output  1  sticky flag: at least one decimated sample was dropped.

Function
REQ-013 Accumulator: signed, DW+DLOG2 bits; on each cen1p5, adds sign-extended snd; never overflows.
REQ-014 Counter cnt (DLOG2 bits) increments on each cen1p5; wraps from 2^DLOG2-1 to 0.
REQ-015 On the cen1p5 where cnt==2^DLOG2-1: stage-1 register takes (acc+snd) arithmetically shifted right by DLOG2 (floor); acc loads 0; st1_valid is set for one clk.
REQ-016 Stage 2, one clk after st1_valid: gain applied -- 0 gives 0, 1 gives >>>1 (floor), 2 passes, 3 gives <<1 saturated to 0x7FFF / 0x8000; result pushed to the FIFO the same edge.
REQ-017 Latency: sample_valid rises 2 clk edges after the cen1p5 edge that completes a block, if the FIFO was empty.
REQ-018 FIFO: show-ahead, depth 2^FLOG2; sample is driven from the head entry; pop occurs on sample_valid && sample_ready.
REQ-019 Push while full with no pop: the new sample is dropped, FIFO contents are unchanged, and ovf is set.
REQ-020 Push and pop on the same edge while full: both occur; no drop; ovf unchanged.
REQ-021 Push and pop on the same edge while holding one entry: the count stays 1 and the new sample becomes the head.
REQ-022 Pointers wrap modulo 2^FLOG2; occupancy is counted with FLOG2+1 bits to separate full from empty.
REQ-023 A gain change affects only samples entering stage 2 after the change; stored FIFO entries are not rescaled.
REQ-024 A cen1p5 that coincides with stage-2 activity is accumulated normally; there are no stalls on the input side.

Reset
REQ-025 On rst: acc=0, cnt=0, st1_valid=0, FIFO empty, sample=0, sample_valid=0, ovf=0.
REQ-026 rst in mid-block discards the partial sum; the next block starts at the first cen1p5 after rst falls.
REQ-027 rst overrides cen1p5 and sample_ready on the same edge.

Structure
REQ-028 The gain encodings (GAIN_MUTE=0, GAIN_HALF=1, GAIN_UNITY=2, GAIN_DOUBLE=3) are defined in the shared sound definitions package jt1943_snd_pkg.
REQ-029 The FIFO is one sub-module, jt1943_snd_fifo (parameters DW and FLOG2; push, pop, full, empty), instantiated once.

Verification
REQ-030 Constant snd=1000, gain=2, ready=1, 32 strobes -> one sample of 1000, with sample_valid rising 2 clk after the 32nd strobe.
REQ-031 snd=20000 then -20000, gain=3 -> samples 32767 and -32768; with gain=1, snd=-3 -> -2.
REQ-032 Ramp snd=0..31, gain=2 -> sample 15 (floor of 496/32).
REQ-033 ready=0 for 5 blocks -> 4 entries held, ovf=1, 5th block lost; with ready=1 afterwards, the first 4 values drain in order.
REQ-034 FIFO full, ready=1 on the edge of a push -> no drop, ovf stays 0, occupancy stays 4.
REQ-035 rst pulsed after 10 strobes of snd=500, then snd=100 -> the first output is 100 and ovf=0.
